// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe: three-stage pipelined radix-2 DIT butterfly.
//   out1 = A + B*W, out2 = A - B*W, with optional per-sample divide-by-2
//   and a valid/ready handshake that stalls the whole pipeline together.
// Build option: define BFLY_SATURATE_EN to clamp out-of-range results and
// enable the sticky ovf flag; otherwise results wrap and ovf reads 0.

module butterfly_r2_pipe #(
  parameter int unsigned BW = 16,
  parameter int unsigned TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BW-1:0] xin1,
  input  logic signed [BW-1:0] yin1,
  input  logic signed [BW-1:0] xin2,
  input  logic signed [BW-1:0] yin2,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [BW-1:0] xout1,
  output logic signed [BW-1:0] yout1,
  output logic signed [BW-1:0] xout2,
  output logic signed [BW-1:0] yout2,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  // Widths: product, full-precision sum, rounded twiddle product, stage-3 sum
  localparam int unsigned PW = BW + TW;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned RW = BW + 2;
  localparam int unsigned EW = BW + 3;

  // Half-LSB of the Q1.(TW-1) product for round half-up
  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (TW - 2);
  localparam logic signed [EW-1:0] MAXV = EW'((1 << (BW - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);

  // One reduced output component plus its out-of-range indication
  typedef struct packed {
    logic          ovf;
    logic [BW-1:0] val;
  } red_t;

  // Optional halving with round half-up, then reduction to BW bits
  function automatic red_t finish_sample(input logic signed [EW-1:0] s,
                                         input logic                 sc);
    logic signed [EW-1:0] v;
    red_t                 r;
    v     = sc ? ((s + EW'(1)) >>> 1) : s;
    r.ovf = (v > MAXV) || (v < MINV);
`ifdef BFLY_SATURATE_EN
    if (v > MAXV)      r.val = BW'(MAXV);
    else if (v < MINV) r.val = BW'(MINV);
    else               r.val = BW'(v);
`else
    r.val = BW'(v);
`endif
    return r;
  endfunction

  logic adv;

  // Stage 1 state
  logic                 v1;
  logic signed [PW-1:0] p_xr, p_yi, p_xi, p_yr;
  logic signed [BW-1:0] a1_x, a1_y;
  logic                 sc1;

  // Stage 2 state
  logic                 v2;
  logic signed [RW-1:0] t_r, t_i;
  logic signed [BW-1:0] a2_x, a2_y;
  logic                 sc2;

  // Stage 3 valid
  logic v3;

  // Combinational intermediates
  logic signed [PW-1:0] m_xr_c, m_yi_c, m_xi_c, m_yr_c;
  logic signed [SW-1:0] tr_full_c, ti_full_c, tr_sh_c, ti_sh_c;
  logic signed [EW-1:0] s1x_c, s1y_c, s2x_c, s2y_c;
  red_t                 r1x_c, r1y_c, r2x_c, r2y_c;
  logic                 ovf_any_c;

  // Whole pipeline advances unless a finished result is blocked downstream
  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // Stage 1 multipliers: four real partial products of B*W
  assign m_xr_c = PW'(xin2) * PW'(wr);
  assign m_yi_c = PW'(yin2) * PW'(wi);
  assign m_xi_c = PW'(xin2) * PW'(wi);
  assign m_yr_c = PW'(yin2) * PW'(wr);

  // Stage 1 register: products, A and scale captured on a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      p_xr <= '0;
      p_yi <= '0;
      p_xi <= '0;
      p_yr <= '0;
      a1_x <= '0;
      a1_y <= '0;
      sc1  <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        p_xr <= m_xr_c;
        p_yi <= m_yi_c;
        p_xi <= m_xi_c;
        p_yr <= m_yr_c;
        a1_x <= xin1;
        a1_y <= yin1;
        sc1  <= scale;
      end
    end
  end

  // Stage 2 combine: complex product sums, rounded back to data scale
  always_comb begin
    tr_full_c = SW'(p_xr) - SW'(p_yi);
    ti_full_c = SW'(p_xi) + SW'(p_yr);
    tr_sh_c   = (tr_full_c + RND) >>> (TW - 1);
    ti_sh_c   = (ti_full_c + RND) >>> (TW - 1);
  end

  // Stage 2 register: rounded twiddle product travels with A and scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      t_r  <= '0;
      t_i  <= '0;
      a2_x <= '0;
      a2_y <= '0;
      sc2  <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        t_r  <= RW'(tr_sh_c);
        t_i  <= RW'(ti_sh_c);
        a2_x <= a1_x;
        a2_y <= a1_y;
        sc2  <= sc1;
      end
    end
  end

  // Stage 3 add/sub with headroom, then scale and reduce each component
  always_comb begin
    s1x_c     = EW'(a2_x) + EW'(t_r);
    s1y_c     = EW'(a2_y) + EW'(t_i);
    s2x_c     = EW'(a2_x) - EW'(t_r);
    s2y_c     = EW'(a2_y) - EW'(t_i);
    r1x_c     = finish_sample(s1x_c, sc2);
    r1y_c     = finish_sample(s1y_c, sc2);
    r2x_c     = finish_sample(s2x_c, sc2);
    r2y_c     = finish_sample(s2y_c, sc2);
    ovf_any_c = r1x_c.ovf | r1y_c.ovf | r2x_c.ovf | r2y_c.ovf;
  end

  // Output register: holds while a result waits on out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      xout1 <= '0;
      yout1 <= '0;
      xout2 <= '0;
      yout2 <= '0;
    end else if (adv) begin
      v3 <= v2;
      if (v2) begin
        xout1 <= r1x_c.val;
        yout1 <= r1y_c.val;
        xout2 <= r2x_c.val;
        yout2 <= r2y_c.val;
      end
    end
  end

`ifdef BFLY_SATURATE_EN
  // Sticky overflow: a new overflow wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (adv && v2 && ovf_any_c) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  // Wrapping build: no overflow reporting
  logic unused_sig;
  assign ovf        = 1'b0;
  assign unused_sig = ^{ovf_clr, ovf_any_c};
`endif

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb_butterfly_r2_pipe: directed vectors and handshake/reset sequences for
// butterfly_r2_pipe (BW = TW = 16). Expectations follow BFLY_SATURATE_EN.

module tb_butterfly_r2_pipe;

  localparam int BW = 16;
  localparam int TW = 16;
`ifdef BFLY_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] xin1, yin1, xin2, yin2;
  logic signed [TW-1:0] wr, wi;
  logic                 scale;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] xout1, yout1, xout2, yout2;
  logic                 ovf;
  logic                 ovf_clr;

  butterfly_r2_pipe #(.BW(BW), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .xin1     (xin1),
    .yin1     (yin1),
    .xin2     (xin2),
    .yin2     (yin2),
    .wr       (wr),
    .wi       (wi),
    .scale    (scale),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xout1    (xout1),
    .yout1    (yout1),
    .xout2    (xout2),
    .yout2    (yout2),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Inputs A, B, W, scale; expected out1, out2, ovf
  typedef struct {
    int ax, ay, bx, by, wr, wi, sc;
    int x1, y1, x2, y2, ov;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    xin1  = 16'(v.ax);
    yin1  = 16'(v.ay);
    xin2  = 16'(v.bx);
    yin2  = 16'(v.by);
    wr    = 16'(v.wr);
    wi    = 16'(v.wi);
    scale = v.sc[0];
  endtask

  // One-cycle ovf_clr pulse, then ovf must read 0
  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clear", int'(ovf), 0);
  endtask

  // Single transfer into an empty pipeline; checks latency, data and ovf.
  // clr_last raises ovf_clr on the edge that registers the result.
  task automatic send_vec(input vec_t v, input bit clr_last, input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    out_ready = 1'b1;
    drive(v);
    in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, int'(in_ready), 1);
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0;
      ovf_clr  = (clr_last && n == 2);
      if (out_valid) got = 1'b1;
    end
    ovf_clr = 1'b0;
    chk({tag, " latency"}, n, 3);
    chk({tag, " xout1"}, int'(xout1), v.x1);
    chk({tag, " yout1"}, int'(yout1), v.y1);
    chk({tag, " xout2"}, int'(xout2), v.x2);
    chk({tag, " yout2"}, int'(yout2), v.y2);
    chk({tag, " ovf"}, int'(ovf), v.ov);
  endtask

  // Streaming sample k: A = (100k+1, -50k), B = (10k, 0), W = -1
  function automatic vec_t stream_vec(input int k);
    vec_t v;
    v = '{100*k + 1, -50*k, 10*k, 0, -32768, 0, 0,
          90*k + 1, -50*k, 110*k + 1, -50*k, 0};
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   snd, rcv, cyc, stale;
    bit   hold;
    int   held1, held2;

    vecs[0] = '{1000, -2000, 300, 400, -32768, 0, 0, 700, -2400, 1300, -1600, 0};
    vecs[1] = '{0, 0, 300, 400, 0, -32768, 0, 400, -300, -400, 300, 0};
    vecs[2] = '{0, 0, 300, 400, 0, -32768, 1, 200, -150, -200, 150, 0};
    vecs[3] = '{32767, 0, 32767, 0, -32768, 0, 0, 0, 0, (SAT != 0) ? 32767 : -2, 0, SAT};
    vecs[4] = '{32767, 0, 32767, 0, -32768, 0, 1, 0, 0, 32767, 0, 0};
    vecs[5] = '{-3, 5, 0, 0, -32768, 0, 1, -1, 3, -1, 3, 0};
    vecs[6] = '{-32768, 0, 32767, 0, -32768, 0, 0, (SAT != 0) ? -32768 : 1, 0, -1, 0, SAT};
    vecs[7] = '{10, 20, 1000, 2000, 16384, -8192, 0, 1010, 770, -990, -730, 0};
    vecs[8] = '{0, 0, 1, -1, 16384, 0, 0, 1, 0, -1, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    v         = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset xout1", int'(xout1), 0);
    chk("reset yout2", int'(yout2), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      pulse_clr();
      send_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Sticky ovf: hold, survive a clean sample, clear, set beats clear
    pulse_clr();
    send_vec(vecs[3], 1'b0, "sticky_set");
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_hold ovf", int'(ovf), SAT);
    v    = vecs[4];
    v.ov = SAT;
    send_vec(v, 1'b0, "sticky_keep");
    pulse_clr();
    send_vec(vecs[3], 1'b1, "set_wins");
    pulse_clr();

    // Backpressure stream: out_ready low for cycles 4..7
    snd  = 0;
    rcv  = 0;
    cyc  = 0;
    hold = 1'b0;
    held1 = 0;
    held2 = 0;
    while (rcv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (snd < 8);
      if (snd < 8) drive(stream_vec(snd));
      #1;
      chk($sformatf("bp in_ready c%0d", cyc), int'(in_ready),
          int'(!(out_valid && !out_ready)));
      if (hold && out_valid) begin
        chk($sformatf("bp stable1 c%0d", cyc), int'({xout1, yout1}), held1);
        chk($sformatf("bp stable2 c%0d", cyc), int'({xout2, yout2}), held2);
      end
      hold  = out_valid && !out_ready;
      held1 = int'({xout1, yout1});
      held2 = int'({xout2, yout2});
      if (out_valid && out_ready) begin
        v = stream_vec(rcv);
        chk($sformatf("bp s%0d xout1", rcv), int'(xout1), v.x1);
        chk($sformatf("bp s%0d yout1", rcv), int'(yout1), v.y1);
        chk($sformatf("bp s%0d xout2", rcv), int'(xout2), v.x2);
        rcv++;
      end
      if (in_valid && in_ready) snd++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp received", rcv, 8);
    chk("bp sent", snd, 8);

    // Reset with three samples in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(stream_vec(k));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("flight out_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst xout1", int'(xout1), 0);
    chk("midrst xout2", int'(xout2), 0);
    chk("midrst ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("postrst stale outputs", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
